// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cic_pkg
//  Description : Shared definitions for the CIC readout controller: the
//                controller state encoding, the sample sequence number
//                width, the default data width and a counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cic_pkg;

   // Controller states; encoding is fixed so that a status readout can
   // report the raw state value.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RUN    = 2'd3
   } cic_state_t;

   localparam int SEQ_WIDTH          = 8;
   localparam int DEFAULT_DATA_WIDTH = 16;

   localparam logic [SEQ_WIDTH-1:0] SEQ_ONE = SEQ_WIDTH'(1);

   // Bits needed to hold the value max_val (never less than one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cic_strobe_edge.sv
`default_nettype none
// ============================================================================
//  Module      : cic_strobe_edge
//  Description : Rising-edge detector for the CIC output strobe. One history
//                register; rise is high in the cycle where strobe is 1 and
//                the previous sample was 0. clr empties the history so the
//                first high sample after a clear counts as an edge.
//  Ports       : clk, rst (sync, active high), clr (sync history clear),
//                strobe (level input), rise (combinational edge flag)
//  Revision    : 1.0  initial release
// ============================================================================
module cic_strobe_edge (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic strobe,
   output logic rise
);

   logic strobe_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         strobe_q <= 1'b0;
      end else begin
         strobe_q <= strobe;
      end
   end

   assign rise = strobe & ~strobe_q;

endmodule
`default_nettype wire

// File: rtl/cic_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cic_readout_ctrl
//  Description : Run controller for the pruned CIC decimator. Holds the CIC
//                in reset for a flush period after start, discards the first
//                SETTLE_SAMPLES decimated outputs, then captures each output
//                on the rising edge of the CIC strobe and offers it through a
//                valid/ready handshake with a sticky overrun flag.
//  Ports       : i_clk, i_rst (sync, active high), i_start, i_stop,
//                o_cic_en, o_cic_rst, i_cic_clk, i_cic_data,
//                o_data, o_valid, i_ready, o_busy, o_overrun,
//                o_seq (only with CIC_CTRL_SEQ_EN)
//  Option      : CIC_CTRL_SEQ_EN adds an 8-bit per-sample sequence number
//                o_seq, registered together with o_data.
//  Revision    : 1.0  initial release
// ============================================================================
module cic_readout_ctrl
   import cic_pkg::*;
#(
   parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
   parameter int SETTLE_SAMPLES = 3,
   parameter int FLUSH_CYCLES   = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_stop,
   output logic                  o_cic_en,
   output logic                  o_cic_rst,
   input  logic                  i_cic_clk,
   input  logic [DATA_WIDTH-1:0] i_cic_data,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic                  o_busy,
`ifdef CIC_CTRL_SEQ_EN
   output logic [SEQ_WIDTH-1:0]  o_seq,
`endif
   output logic                  o_overrun
);

   localparam int FCW = cnt_width(FLUSH_CYCLES);
   localparam int SCW = cnt_width(SETTLE_SAMPLES);

   cic_state_t     state;
   logic [FCW-1:0] flush_cnt;
   logic [SCW-1:0] settle_cnt;
   logic           rise;
   logic           flush_done;
   logic           start_ok;
   logic           capture;

   assign flush_done = (state == ST_FLUSH) && (flush_cnt == '0);
   // Stop wins over start when both arrive in the same cycle.
   assign start_ok   = (state == ST_IDLE) && i_start && !i_stop;
   // An edge coinciding with a stop request is dropped.
   assign capture    = (state == ST_RUN) && rise && !i_stop;

   // History is emptied on leaving FLUSH so the first strobe after the CIC
   // comes out of reset is always seen as an edge.
   cic_strobe_edge u_strobe_edge (
      .clk    (i_clk),
      .rst    (i_rst),
      .clr    (flush_done),
      .strobe (i_cic_clk),
      .rise   (rise)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= ST_IDLE;
         flush_cnt  <= '0;
         settle_cnt <= '0;
         o_cic_en   <= 1'b0;
         o_cic_rst  <= 1'b1;
         o_busy     <= 1'b0;
         o_data     <= '0;
         o_valid    <= 1'b0;
         o_overrun  <= 1'b0;
      end else begin
         // Output holding register. A capture during a transfer simply
         // replaces the word; only a capture over an unaccepted word is an
         // overrun.
         if (capture) begin
            o_data  <= i_cic_data;
            o_valid <= 1'b1;
            if (o_valid && !i_ready) begin
               o_overrun <= 1'b1;
            end
         end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
         end

         if (i_stop && (state != ST_IDLE)) begin
            // Pending o_valid word is deliberately left in place.
            state      <= ST_IDLE;
            flush_cnt  <= '0;
            settle_cnt <= '0;
            o_cic_en   <= 1'b0;
            o_cic_rst  <= 1'b1;
            o_busy     <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_ok) begin
                     state     <= ST_FLUSH;
                     flush_cnt <= FCW'(FLUSH_CYCLES - 1);
                     o_busy    <= 1'b1;
                     o_valid   <= 1'b0;
                     o_overrun <= 1'b0;
                  end
               end
               ST_FLUSH: begin
                  if (flush_done) begin
                     state      <= (SETTLE_SAMPLES == 0) ? ST_RUN : ST_SETTLE;
                     settle_cnt <= SCW'(SETTLE_SAMPLES);
                     o_cic_rst  <= 1'b0;
                     o_cic_en   <= 1'b1;
                  end else begin
                     flush_cnt <= flush_cnt - FCW'(1);
                  end
               end
               ST_SETTLE: begin
                  if (rise) begin
                     if (settle_cnt == SCW'(1)) begin
                        state      <= ST_RUN;
                        settle_cnt <= '0;
                     end else begin
                        settle_cnt <= settle_cnt - SCW'(1);
                     end
                  end
               end
               ST_RUN: begin
                  state <= ST_RUN;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

`ifdef CIC_CTRL_SEQ_EN
   // Every capture consumes a number, including ones that overwrite an
   // unread word, so gaps downstream expose overruns.
   logic [SEQ_WIDTH-1:0] seq_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst || start_ok) begin
         seq_cnt <= '0;
         o_seq   <= '0;
      end else if (capture) begin
         o_seq   <= seq_cnt;
         seq_cnt <= seq_cnt + SEQ_ONE;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cic_readout_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic_readout_ctrl
//  Description : Self-checking bench for cic_readout_ctrl. A reference model
//                expressed in elapsed cycles and counted strobe edges predicts
//                every output each cycle; directed scenarios use a stub CIC
//                strobing every 8 cycles, followed by a randomized phase.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cic_readout_ctrl;

   localparam int DW     = 16;
   localparam int SETTLE = 3;
   localparam int FLUSH  = 2;

   logic          clk = 1'b0;
   logic          rst, start, stop, ready, cic_clk;
   logic [DW-1:0] cic_data;
   logic          cic_en, cic_rst, valid, busy, overrun;
   logic [DW-1:0] data;
`ifdef CIC_CTRL_SEQ_EN
   logic [7:0]    seq;
`endif

   always #5 clk = ~clk;

   cic_readout_ctrl #(
      .DATA_WIDTH     (DW),
      .SETTLE_SAMPLES (SETTLE),
      .FLUSH_CYCLES   (FLUSH)
   ) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_stop     (stop),
      .o_cic_en   (cic_en),
      .o_cic_rst  (cic_rst),
      .i_cic_clk  (cic_clk),
      .i_cic_data (cic_data),
      .o_data     (data),
      .o_valid    (valid),
      .i_ready    (ready),
      .o_busy     (busy),
`ifdef CIC_CTRL_SEQ_EN
      .o_seq      (seq),
`endif
      .o_overrun  (overrun)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   // A run starts at the edge where start is accepted; the CIC is enabled
   // FLUSH edges later. Strobe edges seen while enabled are counted; the
   // first SETTLE of them are thrown away, later ones are captured.
   bit          m_active, m_valid, m_ovr, m_prev, exp_en;
   logic [DW-1:0] m_data;
   int          m_en_edge, m_edges, m_seq, m_seq_next;

   task automatic model_step();
      bit en_now, prev_eff, rise_m, cap, xfer;
      if (rst) begin
         m_active = 0; m_valid = 0; m_ovr = 0; m_prev = 0; m_data = '0;
         m_en_edge = 0; m_edges = 0; m_seq = 0; m_seq_next = 0;
      end else begin
         en_now   = m_active && (cyc >= m_en_edge);
         prev_eff = (cyc == m_en_edge) ? 1'b0 : m_prev;
         rise_m   = en_now && cic_clk && !prev_eff;
         cap      = rise_m && !stop && (m_edges >= SETTLE);
         xfer     = m_valid && ready;
         if (rise_m && !cap) m_edges++;
         if (cap) begin
            if (m_valid && !ready) m_ovr = 1;
            m_data     = cic_data;
            m_valid    = 1;
            m_seq      = m_seq_next;
            m_seq_next = (m_seq_next + 1) % 256;
         end else if (xfer) begin
            m_valid = 0;
         end
         if (m_active && stop) begin
            m_active = 0;
         end else if (!m_active && start && !stop) begin
            m_active = 1; m_en_edge = cyc + 1 + FLUSH; m_edges = 0;
            m_valid = 0; m_ovr = 0; m_seq = 0; m_seq_next = 0;
         end
         m_prev = cic_clk;
      end
      exp_en = m_active && (cyc + 1 >= m_en_edge);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      cyc++;
      check("busy",    32'(busy),    32'(m_active));
      check("cic_en",  32'(cic_en),  32'(exp_en));
      check("cic_rst", 32'(cic_rst), 32'(!exp_en));
      check("valid",   32'(valid),   32'(m_valid));
      check("data",    32'(data),    32'(m_data));
      check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef CIC_CTRL_SEQ_EN
      check("seq",     32'(seq),     32'(m_seq));
`endif
   endtask

   // ---------------- stub CIC: strobe every 8 cycles while out of reset ---
   int st_ph  = 0;
   int st_cnt = 0;

   task automatic stub_step();
      if (cic_rst) begin
         st_ph = 0; st_cnt = 0; cic_clk = 0;
      end else begin
         st_ph = (st_ph + 1) % 8;
         if (st_ph == 4) begin
            cic_clk  = 1;
            cic_data = 16'h0100 + 16'(st_cnt);
            st_cnt++;
         end else if (st_ph == 0) begin
            cic_clk = 0;
         end
      end
   endtask

   task automatic run_stub(input int n);
      for (int i = 0; i < n; i++) begin
         stub_step();
         tick();
      end
   endtask

   task automatic pulse_start();
      start = 1; stub_step(); tick(); start = 0;
   endtask

   task automatic pulse_stop();
      stop = 1; stub_step(); tick(); stop = 0;
   endtask

   // Run the stub until o_valid is seen, bounded.
   task automatic wait_valid(input string tag);
      bit seen = 0;
      for (int i = 0; i < 64 && !seen; i++) begin
         run_stub(1);
         seen = valid;
      end
      check(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int start_cyc, en_cyc;
      logic [DW-1:0] first_data;
      bit got_first, hit;
      rst = 1; start = 0; stop = 0; ready = 1; cic_clk = 0; cic_data = '0;

      // Reset state
      repeat (3) tick();
      rst = 0;
      run_stub(3);

      // A: start-up, flush, settle discard, first capture
      start_cyc = cyc;
      pulse_start();
      en_cyc = -1; got_first = 0; first_data = '0;
      for (int i = 0; i < 80; i++) begin
         run_stub(1);
         if (cic_en && en_cyc < 0) en_cyc = cyc;
         if (valid && !got_first) begin got_first = 1; first_data = data; end
      end
      check("en_rise_delay", 32'(en_cyc - start_cyc), 32'(1 + FLUSH));
      check("first_data",    32'(first_data),         32'h0103);

      // B: capture coinciding with a transfer
      ready = 0;
      wait_valid("b_wait_valid");
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         stub_step();
         if (st_ph == 4) begin ready = 1; hit = 1; end
         tick();
      end
      check("b_valid_kept", 32'(valid),   32'd1);
      check("b_no_overrun", 32'(overrun), 32'd0);
      run_stub(4);

      // C: overrun across two strobes, sticky until next start
      ready = 0;
      run_stub(20);
      check("c_overrun_set", 32'(overrun), 32'd1);
      ready = 1;
      run_stub(20);
      check("c_overrun_sticky", 32'(overrun), 32'd1);

      // D: stop on a strobe cycle with a held sample
      ready = 0;
      run_stub(10);
      hit = 0;
      for (int i = 0; i < 20 && !hit; i++) begin
         stub_step();
         if (st_ph == 4) begin stop = 1; hit = 1; end
         tick();
         stop = 0;
      end
      check("d_en_low",   32'(cic_en),  32'd0);
      check("d_rst_high", 32'(cic_rst), 32'd1);
      check("d_held",     32'(valid),   32'd1);
      run_stub(3);
      ready = 1;
      run_stub(2);
      check("d_delivered", 32'(valid), 32'd0);

      // E: start and stop together in IDLE
      start = 1; stop = 1; stub_step(); tick(); start = 0; stop = 0;
      check("e_idle", 32'(busy), 32'd0);

      // F: start during RUN is ignored
      pulse_start();
      run_stub(40);
      pulse_start();
      run_stub(10);
      check("f_no_reflush", 32'(cic_en), 32'd1);
      pulse_stop();

      // G: reset while settling
      pulse_start();
      run_stub(4);
      rst = 1; stub_step(); tick(); rst = 0;
      check("g_reset_busy", 32'(busy), 32'd0);
      run_stub(3);

`ifdef CIC_CTRL_SEQ_EN
      // H: 300 captures, sequence numbers wrap, restart returns to 0
      begin
         int caps = 0;
         logic [7:0] last_seq = '0;
         ready = 1;
         pulse_start();
         for (int i = 0; i < 3000 && caps < 300; i++) begin
            run_stub(1);
            if (valid) begin caps++; last_seq = seq; end
         end
         check("h_caps",     32'(caps),     32'd300);
         check("h_last_seq", 32'(last_seq), 32'd43);
         pulse_stop();
         run_stub(2);
         pulse_start();
         wait_valid("h_restart_valid");
         check("h_restart_seq", 32'(seq), 32'd0);
         pulse_stop();
      end
`endif

      // I: randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(2) == 0) begin
            cic_clk = ~cic_clk;
            if (cic_clk) cic_data = DW'($urandom);
         end
         ready = ($urandom_range(9) < 7);
         start = ($urandom_range(19) == 0);
         stop  = ($urandom_range(59) == 0);
         rst   = ($urandom_range(299) == 0);
         tick();
      end
      rst = 0; start = 0; stop = 0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
